// File: rtl/prog_load_if.sv
// Loader bus: host control and byte stream in, program-memory load port and status out.
interface prog_load_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
);
  logic               start;
  logic               abort;
  logic               in_valid;
  logic [7:0]         in_byte;
  logic               in_ready;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_instr;
  logic               busy;
  logic               load_done;
  logic               core_hold;
  logic               fmt_err;

  modport master (
    output start, abort, in_valid, in_byte,
    input  in_ready, load_en, load_addr, load_instr, busy, load_done, core_hold, fmt_err
  );

  modport slave (
    input  start, abort, in_valid, in_byte,
    output in_ready, load_en, load_addr, load_instr, busy, load_done, core_hold, fmt_err
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// Program-memory loader: pairs host bytes into INSTR_W-bit words and writes DEPTH of them,
// holding the core in LOAD until the whole image is in place. INSTR_W must be 9..15.
module prog_load_ctrl #(
  parameter int DEPTH   = 10,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
) (
  input logic        clk_i,
  input logic        rst_ni,
  prog_load_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WRITE, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic               in_ready_q, load_en_q, busy_q, done_q, hold_q, fmt_err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         lo_q;
  logic [INSTR_W-1:0] instr_q;
  logic               xfer, hi_bad;

  assign xfer   = bus.in_valid & in_ready_q;
  assign hi_bad = |bus.in_byte[7:INSTR_W-8];

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (bus.start) state_d = S_LO;
        S_LO:           if (xfer) state_d = S_HI;
        S_HI:           if (xfer) state_d = S_WRITE;
        S_WRITE:        state_d = (addr_q == LAST_ADDR) ? S_DONE : S_LO;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      load_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b1;
      fmt_err_q  <= 1'b0;
      addr_q     <= '0;
      lo_q       <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_LO) || (state_d == S_HI);
      load_en_q  <= (state_d == S_WRITE);
      busy_q     <= (state_d == S_LO) || (state_d == S_HI) || (state_d == S_WRITE);
      done_q     <= (state_d == S_DONE);
      hold_q     <= (state_d != S_DONE);
      if (!bus.abort) begin
        case (state_q)
          S_IDLE, S_DONE: if (bus.start) begin
            addr_q    <= '0;
            fmt_err_q <= 1'b0;
          end
          S_LO: if (xfer) lo_q <= bus.in_byte;
          S_HI: if (xfer) begin
            instr_q <= {bus.in_byte[INSTR_W-9:0], lo_q};
            if (hi_bad) fmt_err_q <= 1'b1;
          end
          S_WRITE: addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Abort must kill the strobe in the very cycle it arrives, so it gates the registered enable.
  assign bus.load_en    = load_en_q & ~bus.abort;
  assign bus.in_ready   = in_ready_q;
  assign bus.load_addr  = addr_q;
  assign bus.load_instr = instr_q;
  assign bus.busy       = busy_q;
  assign bus.load_done  = done_q;
  assign bus.core_hold  = hold_q;
  assign bus.fmt_err    = fmt_err_q;
endmodule
